// File: rtl/toggle_event_rx.sv
// Receive end of a toggle-signalled event link: synchronises the remote toggle line,
// converts each level change into a one-cycle pulse and queues events in a saturating counter.
module toggle_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tog_in,
    output logic              ev_pulse,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  ev_total,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   prev_reg;
    logic                   ev_pulse_reg;
    logic [PEND_W-1:0]      pend_reg;
    logic [PEND_W-1:0]      pend_next;
    logic [CNT_W-1:0]       total_reg;
    logic [CNT_W-1:0]       total_next;
    logic                   ovf_reg;
    logic                   ovf_next;
    logic                   detect;
    logic                   dec;
    logic                   set_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = tog_in;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    // Any difference between the synchronised level and last cycle's level is one event.
    assign detect   = sync_reg[SYNC_STAGES-1] ^ prev_reg;
    assign ev_valid = (pend_reg != '0);
    assign dec      = ev_valid & ev_ready;

    always_comb begin
        pend_next  = pend_reg;
        set_ovf    = 1'b0;
        total_next = total_reg + CNT_W'(detect);
        if (detect && !dec) begin
            if (pend_reg == PEND_MAX) begin
                set_ovf = 1'b1;
            end else begin
                pend_next = pend_reg + PEND_W'(1);
            end
        end else if (!detect && dec) begin
            pend_next = pend_reg - PEND_W'(1);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (set_ovf) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end else begin
            ovf_next = ovf_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= '0;
            prev_reg     <= 1'b0;
            ev_pulse_reg <= 1'b0;
            pend_reg     <= '0;
            total_reg    <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            sync_reg     <= sync_next;
            prev_reg     <= sync_reg[SYNC_STAGES-1];
            ev_pulse_reg <= detect;
            pend_reg     <= pend_next;
            total_reg    <= total_next;
            ovf_reg      <= ovf_next;
        end
    end

    assign ev_pulse = ev_pulse_reg;
    assign pend_cnt = pend_reg;
    assign ev_total = total_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: directed scenarios plus random toggles/ready, checked each
// cycle against an event-schedule reference model.
module tb_toggle_event_rx;

    localparam int SS   = 2;
    localparam int PW   = 2;
    localparam int CW   = 8;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tog_in = 1'b0;
    logic          ev_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          ev_pulse;
    logic          ev_valid;
    logic [PW-1:0] pend_cnt;
    logic [CW-1:0] ev_total;
    logic          overflow;

    toggle_event_rx #(.SYNC_STAGES(SS), .PEND_W(PW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tog_in   (tog_in),
        .ev_pulse (ev_pulse),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .pend_cnt (pend_cnt),
        .ev_total (ev_total),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accepts = 0;
    int ev_at[$];
    int m_pend = 0;
    int m_total = 0;
    int m_ovf = 0;
    int m_pulse = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ev_pulse", 32'(ev_pulse), 32'(m_pulse));
        chk("pend_cnt", 32'(pend_cnt), 32'(m_pend));
        chk("ev_valid", 32'(ev_valid), 32'(m_pend != 0));
        chk("ev_total", 32'(ev_total), 32'(m_total));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        $display("cyc=%0d tog=%0b rdy=%0b clr=%0b pulse=%0b pend=%0d total=%0d ovf=%0b",
                 cyc, tog_in, ev_ready, clr_ovf, ev_pulse, pend_cnt, ev_total, overflow);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pulse"}, 32'(ev_pulse), 32'd0);
        chk({tag, "_pend"},  32'(pend_cnt), 32'd0);
        chk({tag, "_valid"}, 32'(ev_valid), 32'd0);
        chk({tag, "_total"}, 32'(ev_total), 32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
    endtask

    // One clock cycle: apply inputs, advance the model by the spec rules, compare after the edge.
    task automatic cycle(input bit flip, input bit rdy, input bit clr);
        bit inc;
        bit dq;
        if (flip) begin
            tog_in = ~tog_in;
            ev_at.push_back(cyc + 1 + SS);
        end
        ev_ready = rdy;
        clr_ovf  = clr;
        if (ev_valid && rdy) accepts++;
        @(posedge clk);
        cyc++;
        inc = (ev_at.size() > 0) && (ev_at[0] == cyc);
        if (inc) void'(ev_at.pop_front());
        dq = rdy && (m_pend != 0);
        m_pulse = int'(inc);
        m_total = (m_total + int'(inc)) % (1 << CW);
        if (inc && !dq) begin
            if (m_pend == PMAX) m_ovf = 1;
            else begin
                m_pend++;
                if (clr) m_ovf = 0;
            end
        end else begin
            if (!inc && dq) m_pend--;
            if (clr) m_ovf = 0;
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0);
    endtask

    task automatic toggles(input int n, input int gap, input bit rdy);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, rdy, 1'b0);
            idle(gap - 1, rdy);
        end
    endtask

    // Assert reset mid-cycle, confirm outputs clear without a clock edge, release with tog_in=0.
    task automatic do_reset(input int n, input bit wiggle);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        for (int i = 0; i < n; i++) begin
            if (wiggle) tog_in = 1'($urandom);
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        tog_in = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst_end");
        ev_at.delete();
        m_pend = 0; m_total = 0; m_ovf = 0; m_pulse = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with the toggle line wiggling, release low: no event appears.
        do_reset(8, 1'b1);
        idle(6, 1'b0);

        // Latency: pulse appears in the third cycle after the flip is applied.
        cycle(1'b1, 1'b0, 1'b0);
        chk("lat_e0", 32'(ev_pulse), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("lat_e1", 32'(ev_pulse), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("lat_pulse", 32'(ev_pulse), 32'd1);
        chk("lat_pend", 32'(pend_cnt), 32'd1);
        chk("lat_total", 32'(ev_total), 32'd1);
        chk("lat_valid", 32'(ev_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("lat_after", 32'(ev_pulse), 32'd0);
        idle(3, 1'b1);

        // Burst then drain.
        toggles(3, 4, 1'b0);
        idle(4, 1'b0);
        chk("burst_pend", 32'(pend_cnt), 32'd3);
        accepts = 0;
        idle(6, 1'b1);
        chk("drain_accepts", 32'(accepts), 32'd3);
        chk("drain_pend", 32'(pend_cnt), 32'd0);
        chk("drain_valid", 32'(ev_valid), 32'd0);

        // Overflow with a full pending counter, then clear.
        toggles(5, 3, 1'b0);
        idle(4, 1'b0);
        chk("ovf_pend", 32'(pend_cnt), 32'd3);
        chk("ovf_total", 32'(ev_total), 32'd9);
        chk("ovf_flag", 32'(overflow), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("clr_flag", 32'(overflow), 32'd0);
        chk("clr_pend", 32'(pend_cnt), 32'd3);

        // Accept coinciding with an event at full: no change, no overflow.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("sim_pulse", 32'(ev_pulse), 32'd1);
        chk("sim_pend", 32'(pend_cnt), 32'd3);
        chk("sim_ovf", 32'(overflow), 32'd0);
        idle(2, 1'b0);

        // Drop and clear on the same edge: the flag stays set.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("setwins_ovf", 32'(overflow), 32'd1);
        chk("setwins_total", 32'(ev_total), 32'd11);
        idle(2, 1'b0);

        // Total-count wrap after 256 events from reset.
        do_reset(2, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'($urandom), 1'b0);
            cycle(1'b0, 1'($urandom), 1'b0);
        end
        idle(4, 1'b0);
        chk("wrap_total", 32'(ev_total), 32'd0);

        // Async reset in the middle of a burst.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end
        do_reset(2, 1'b0);
        idle(4, 1'b0);

        // Random toggles respecting the two-cycle spacing, random ready and clears.
        for (int i = 0; i < 400; i++) begin
            int gap;
            gap = int'($urandom_range(5, 2));
            cycle(1'b1, 1'($urandom), ($urandom_range(15, 0) == 0));
            for (int j = 1; j < gap; j++)
                cycle(1'b0, ($urandom_range(3, 0) == 0), ($urandom_range(15, 0) == 0));
        end
        idle(6, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
